// File: rtl/fifo_mon_pkg.sv
// Shared types, fire-bit indices and width helper for the FIFO occupancy monitor.
package fifo_mon_pkg;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_ERR
   } mon_state_e;

   localparam int FIRE_OVF   = 0;
   localparam int FIRE_UDF   = 1;
   localparam int FIRE_EMPTY = 2;
   localparam int FIRE_FULL  = 3;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mon_cnt.sv
// Bounded up/down occupancy counter (0..DEPTH) with synchronous clear and hold.
module fifo_mon_cnt
   import fifo_mon_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_hold,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

   logic [CNT_W-1:0] r_count;

   // Simultaneous inc and dec cancel; saturation keeps the count inside 0..DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (!i_hold) begin
         if (i_inc && !i_dec && r_count != MAX_CNT) begin
            r_count <= r_count + CNT_W'(1);
         end else if (i_dec && !i_inc && r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/fifo_occupancy_monitor.sv
// FIFO protocol monitor: reference occupancy, ovf/udf/flag checks, sticky errors, isolating FSM.
// Define FIFO_MON_HWM_EN to build the high-water-mark register; otherwise hwm is tied to 0.
module fifo_occupancy_monitor
   import fifo_mon_pkg::*;
#(
   parameter  int DEPTH       = 4,
   parameter  bit SIMUL_FULL  = 1'b0,
   parameter  bit SIMUL_EMPTY = 1'b0,
   localparam int CNT_W       = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             in_write_ctrl,
   input  logic             in_read_ctrl,
   input  logic             out_is_empty,
   input  logic             out_is_full,
   input  logic             clear_err,
   output logic [CNT_W-1:0] count,
   output logic [3:0]       fire,
   output logic [3:0]       err_sticky,
   output logic [CNT_W-1:0] hwm,
   output mon_state_e       o_dbg_state
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   mon_state_e r_state;
   logic [3:0] r_fire;
   logic [3:0] r_sticky;

   logic       w_run;
   logic       w_at_full;
   logic       w_at_empty;
   logic       w_ovf;
   logic       w_udf;
   logic       w_cnt_hold;
   logic [3:0] w_events;

   assign w_at_full  = (count == FULL_CNT);
   assign w_at_empty = (count == '0);

   // Checks only run in ST_RUN; clear_err masks everything in its cycle.
   assign w_run = enable & ~clear_err & (r_state == ST_RUN);
   assign w_ovf = w_run & in_write_ctrl & w_at_full  & ~(in_read_ctrl  & SIMUL_FULL);
   assign w_udf = w_run & in_read_ctrl  & w_at_empty & ~(in_write_ctrl & SIMUL_EMPTY);

   always_comb begin
      w_events             = '0;
      w_events[FIRE_OVF]   = w_ovf;
      w_events[FIRE_UDF]   = w_udf;
      w_events[FIRE_EMPTY] = w_run & (out_is_empty != w_at_empty);
      w_events[FIRE_FULL]  = w_run & (out_is_full  != w_at_full);
   end

   // An illegal push/pop is dropped, so the count holds on the violating cycle.
   assign w_cnt_hold = ~enable | (r_state == ST_ERR) | w_ovf | w_udf;

   fifo_mon_cnt #(
      .DEPTH (DEPTH)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (clear_err),
      .i_hold  (w_cnt_hold),
      .i_inc   (in_write_ctrl),
      .i_dec   (in_read_ctrl),
      .o_count (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_INIT;
         r_fire   <= '0;
         r_sticky <= '0;
      end else if (clear_err) begin
         r_state  <= ST_INIT;
         r_fire   <= '0;
         r_sticky <= '0;
      end else begin
         r_fire   <= w_events;
         r_sticky <= r_sticky | w_events;
         if (enable) begin
            case (r_state)
               ST_INIT: r_state <= ST_RUN;
               ST_RUN:  if (w_ovf | w_udf) r_state <= ST_ERR;
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign fire        = r_fire;
   assign err_sticky  = r_sticky;
   assign o_dbg_state = r_state;

`ifdef FIFO_MON_HWM_EN
   logic [CNT_W-1:0] r_hwm;
   logic             w_hwm_up;

   // hwm >= count always holds, so it can only grow when count sits at hwm and steps up.
   assign w_hwm_up = ~w_cnt_hold & in_write_ctrl & ~in_read_ctrl & ~w_at_full & (count == r_hwm);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hwm <= '0;
      end else if (clear_err) begin
         r_hwm <= '0;
      end else if (w_hwm_up) begin
         r_hwm <= r_hwm + CNT_W'(1);
      end
   end

   assign hwm = r_hwm;
`else
   assign hwm = '0;
`endif

endmodule
